// File: rtl/adc_conv_arbiter.sv
// rtl/adc_conv_arbiter.sv - shares one ADC conversion engine between scanner (A) and host (B) requesters
// Optional macro ADC_ARB_RR_EN selects round-robin arbitration instead of fixed B-over-A priority.
module adc_conv_arbiter #(
    parameter int TIMEOUT_CYCLES = 65520,
    parameter int SETUP_CYCLES   = 1
) (
    input  logic       clk3p2M,
    input  logic       reset,
    input  logic       a_req,
    input  logic [4:0] a_chan,
    output logic       a_done,
    output logic [9:0] a_data,
    output logic       a_err,
    input  logic       b_req,
    input  logic [4:0] b_chan,
    output logic       b_done,
    output logic [9:0] b_data,
    output logic       b_err,
    output logic       busy,
    output logic       adc_go,
    output logic [3:0] adc_chan,
    output logic       adc_batt_sel,
    input  logic [9:0] adc_in,
    input  logic       adc_valid
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETUP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        GO,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner_b;
    logic          owner_b_nxt;
    logic          last_owner_b;
    logic          grant_b;
    logic [4:0]    grant_chan;
    logic          grant_illegal;
    logic          req_any;
    logic          timeout_hit;
    logic          setup_last;
    logic [TW-1:0] to_cnt;
    logic [SW-1:0] setup_cnt;

    assign req_any = a_req | b_req;

`ifdef ADC_ARB_RR_EN
    // On a tie the port that was not served last wins, so host polling cannot starve the scanner.
    assign grant_b = b_req & (~a_req | ~last_owner_b);
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner_b;
    assign grant_b = b_req;
`endif

    assign grant_chan    = grant_b ? b_chan : a_chan;
    assign grant_illegal = (grant_chan > 5'd16);
    assign timeout_hit   = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign setup_last    = (setup_cnt == SW'(SETUP_CYCLES - 1));

    always_comb begin
        state_nxt   = state;
        owner_b_nxt = owner_b;
        case (state)
            IDLE: begin
                if (req_any) begin
                    owner_b_nxt = grant_b;
                    state_nxt   = grant_illegal ? DONE : SETUP;
                end
            end
            SETUP: begin
                if (setup_last) begin
                    state_nxt = GO;
                end
            end
            GO: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (adc_valid || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk3p2M) begin
        if (reset) begin
            state        <= IDLE;
            owner_b      <= 1'b0;
            last_owner_b <= 1'b1;
            to_cnt       <= '0;
            setup_cnt    <= '0;
            busy         <= 1'b0;
            adc_go       <= 1'b0;
            adc_chan     <= 4'd0;
            adc_batt_sel <= 1'b0;
            a_done       <= 1'b0;
            b_done       <= 1'b0;
            a_data       <= 10'd0;
            b_data       <= 10'd0;
            a_err        <= 1'b0;
            b_err        <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner_b <= owner_b_nxt;

            // Status outputs are registered from the next state so they line up with the state register.
            busy   <= (state_nxt == SETUP) || (state_nxt == GO) || (state_nxt == WAIT);
            adc_go <= (state_nxt == GO);
            a_done <= (state_nxt == DONE) && !owner_b_nxt;
            b_done <= (state_nxt == DONE) && owner_b_nxt;

            if (state == SETUP && !setup_last) begin
                setup_cnt <= setup_cnt + SW'(1);
            end else begin
                setup_cnt <= '0;
            end

            if (state == WAIT) begin
                to_cnt <= to_cnt + TW'(1);
            end else begin
                to_cnt <= '0;
            end

            if (state == IDLE && req_any) begin
                if (grant_illegal) begin
                    if (grant_b) begin
                        b_data <= 10'd0;
                        b_err  <= 1'b1;
                    end else begin
                        a_data <= 10'd0;
                        a_err  <= 1'b1;
                    end
                end else begin
                    // Mux select stays put after the conversion until the next legal grant.
                    adc_chan     <= grant_chan[3:0];
                    adc_batt_sel <= grant_chan[4];
                end
            end

            if (state == WAIT) begin
                if (adc_valid) begin
                    if (owner_b) begin
                        b_data <= adc_in;
                        b_err  <= 1'b0;
                    end else begin
                        a_data <= adc_in;
                        a_err  <= 1'b0;
                    end
                end else if (timeout_hit) begin
                    if (owner_b) begin
                        b_err <= 1'b1;
                    end else begin
                        a_err <= 1'b1;
                    end
                end
            end

            if (state == DONE) begin
                last_owner_b <= owner_b;
            end
        end
    end

endmodule

// File: tb/tb_adc_conv_arbiter.sv
// tb/tb_adc_conv_arbiter.sv - randomized bench for adc_conv_arbiter against a transaction schedule model
module tb_adc_conv_arbiter;

    localparam int TO   = 16;
    localparam int SU   = 2;
    localparam int NCYC = 4000;

    logic       clk3p2M = 1'b0;
    logic       reset = 1'b1;
    logic       a_req = 1'b0;
    logic [4:0] a_chan = 5'd0;
    logic       b_req = 1'b0;
    logic [4:0] b_chan = 5'd0;
    logic       adc_valid = 1'b0;
    logic [9:0] adc_in = 10'd0;
    logic       a_done, a_err, b_done, b_err, busy, adc_go, adc_batt_sel;
    logic [9:0] a_data, b_data;
    logic [3:0] adc_chan;

    adc_conv_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .SETUP_CYCLES  (SU)
    ) dut (
        .clk3p2M     (clk3p2M),
        .reset       (reset),
        .a_req       (a_req),
        .a_chan      (a_chan),
        .a_done      (a_done),
        .a_data      (a_data),
        .a_err       (a_err),
        .b_req       (b_req),
        .b_chan      (b_chan),
        .b_done      (b_done),
        .b_data      (b_data),
        .b_err       (b_err),
        .busy        (busy),
        .adc_go      (adc_go),
        .adc_chan    (adc_chan),
        .adc_batt_sel(adc_batt_sel),
        .adc_in      (adc_in),
        .adc_valid   (adc_valid)
    );

    always #5 clk3p2M = ~clk3p2M;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [4:0] pick_chan();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 5'd16;
        if (r == 1) return 5'($urandom_range(17, 31));
        return 5'($urandom_range(0, 15));
    endfunction

    // Conversion schedule model: each grant is turned into absolute cycle numbers for go/valid/done.
    bit         active = 1'b0;
    bit         legal = 1'b0;
    bit         own_b = 1'b0;
    bit         last_b = 1'b1;
    bit         keep = 1'b0;
    bit         conv_err = 1'b0;
    int         g = -1, go_c = -1, dn = -1, v_cyc = -1;
    int         a_drop_at = -1, b_drop_at = -1;
    logic [4:0] gchan = 5'd0;
    logic [4:0] ex_chan = 5'd0;
    logic [9:0] conv_data = 10'd0, v_data = 10'd0;
    logic [9:0] ex_a_data = 10'd0, ex_b_data = 10'd0;
    bit         ex_a_err = 1'b0, ex_b_err = 1'b0;

    initial begin
        for (int c = 0; c < NCYC; c++) begin
            bit rst_now;
            bit in_wait;
            int d;
            int r;
            @(posedge clk3p2M);
            #1;
            cyc = c;
            rst_now = (c < 3) || (c > 20 && $urandom_range(0, 299) == 0);
            reset = rst_now;

            if (c == a_drop_at) a_req = 1'b0;
            if (c == b_drop_at) b_req = 1'b0;
            if (active && c == g + 1 && $urandom_range(0, 7) == 0) begin
                if (own_b) b_req = 1'b0;
                else a_req = 1'b0;
            end
            if (!a_req && $urandom_range(0, 5) == 0) begin
                a_req  = 1'b1;
                a_chan = pick_chan();
            end
            if (!b_req && $urandom_range(0, 5) == 0) begin
                b_req  = 1'b1;
                b_chan = pick_chan();
            end

            in_wait = active && legal && c > go_c && c < dn;
            if (c == v_cyc) begin
                adc_valid = 1'b1;
                adc_in    = v_data;
            end else if (!in_wait && $urandom_range(0, 7) == 0) begin
                adc_valid = 1'b1;
                adc_in    = 10'($urandom);
            end else begin
                adc_valid = 1'b0;
                adc_in    = 10'($urandom);
            end

            if (active && legal && c == g + 1) ex_chan = gchan;
            if (active && c == dn) begin
                if (own_b) begin
                    if (!keep) ex_b_data = conv_data;
                    ex_b_err = conv_err;
                end else begin
                    if (!keep) ex_a_data = conv_data;
                    ex_a_err = conv_err;
                end
                last_b = own_b;
            end

            check("busy", 32'(busy), 32'(active && legal && c > g && c < dn));
            check("adc_go", 32'(adc_go), 32'(active && legal && c == go_c));
            check("a_done", 32'(a_done), 32'(active && !own_b && c == dn));
            check("b_done", 32'(b_done), 32'(active && own_b && c == dn));
            check("a_data", 32'(a_data), 32'(ex_a_data));
            check("b_data", 32'(b_data), 32'(ex_b_data));
            check("a_err", 32'(a_err), 32'(ex_a_err));
            check("b_err", 32'(b_err), 32'(ex_b_err));
            check("adc_chan", 32'(adc_chan), 32'(ex_chan[3:0]));
            check("adc_batt_sel", 32'(adc_batt_sel), 32'(ex_chan[4]));

            if (rst_now) begin
                active    = 1'b0;
                ex_a_data = 10'd0;
                ex_b_data = 10'd0;
                ex_a_err  = 1'b0;
                ex_b_err  = 1'b0;
                ex_chan   = 5'd0;
                last_b    = 1'b1;
                a_drop_at = -1;
                b_drop_at = -1;
                // A late result from the aborted conversion must be ignored.
                v_cyc     = c + 1;
                v_data    = 10'($urandom);
            end else if (active && c == dn) begin
                active = 1'b0;
            end else if (!active && (a_req || b_req)) begin
`ifdef ADC_ARB_RR_EN
                if (a_req && b_req) own_b = !last_b;
                else own_b = b_req;
`else
                own_b = b_req;
`endif
                gchan  = own_b ? b_chan : a_chan;
                legal  = (gchan <= 5'd16);
                active = 1'b1;
                g      = c;
                if (legal) begin
                    go_c = c + 1 + SU;
                    r = $urandom_range(0, 9);
                    if (r < 7) d = $urandom_range(1, 6);
                    else if (r == 7) d = TO;
                    else d = TO + 1;
                    if (d <= TO) begin
                        dn        = go_c + d + 1;
                        v_cyc     = go_c + d;
                        v_data    = 10'($urandom);
                        conv_data = v_data;
                        conv_err  = 1'b0;
                        keep      = 1'b0;
                    end else begin
                        dn       = go_c + TO + 1;
                        v_cyc    = -1;
                        conv_err = 1'b1;
                        keep     = 1'b1;
                    end
                end else begin
                    go_c      = -1;
                    dn        = c + 1;
                    conv_data = 10'd0;
                    conv_err  = 1'b1;
                    keep      = 1'b0;
                end
                if (own_b) b_drop_at = dn + 1;
                else a_drop_at = dn + 1;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
